// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sharing one i2c_master port; define I2C_ARB_PRIO_EN for fixed priority on requester 0
module i2c_arbiter #(
  parameter int NREQ  = 4,
  parameter int TMO_W = 12
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   rw_i,
  input  logic [7*NREQ-1:0] devadr_i,
  input  logic [8*NREQ-1:0] regadr_i,
  input  logic [5*NREQ-1:0] datnum_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic              err_o,
  output logic              m_enable_o,
  output logic              m_rw_o,
  output logic [6:0]        m_devadr_o,
  output logic [7:0]        m_regadr_o,
  output logic [4:0]        m_datnum_o,
  input  logic              m_busy_i,
  input  logic              m_deverr_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q;
  logic [IW-1:0]     ptr_q, gidx_q, pick_idx, cand;
  logic              pick_valid;
  logic [TMO_W-1:0]  tmo_q;
  logic              tmo_max;
  logic              err_q;
  logic [1:0]        busy_sync, deverr_sync;
  logic              busy_s, deverr_s;
  logic              rw_q;
  logic [6:0]        devadr_q;
  logic [7:0]        regadr_q;
  logic [4:0]        datnum_q;
  int                j;

  assign busy_s     = busy_sync[1];
  assign deverr_s   = deverr_sync[1];
  assign tmo_max    = &tmo_q;
  assign gnt_o      = gnt_q;
  assign m_rw_o     = rw_q;
  assign m_devadr_o = devadr_q;
  assign m_regadr_o = regadr_q;
  assign m_datnum_o = datnum_q;

  // bring the master's nclk-domain status flags into wb_clk_i
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      busy_sync   <= 2'b00;
      deverr_sync <= 2'b00;
    end else begin
      busy_sync   <= {busy_sync[0], m_busy_i};
      deverr_sync <= {deverr_sync[0], m_deverr_i};
    end
  end

  // next requester: first set bit after the pointer, wrapping; optionally requester 0 first
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    j          = 0;
`ifdef I2C_ARB_PRIO_EN
    if (req_i[0]) begin
      pick_valid = 1'b1;
    end
`endif
    for (int i = 1; i <= NREQ; i++) begin
      j    = (int'(ptr_q) + i) % NREQ;
      cand = IW'(j);
      if (!pick_valid && req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d    = state_q;
    m_enable_o = 1'b0;
    done_o     = '0;
    err_o      = 1'b0;
    case (state_q)
      IDLE: if (pick_valid) state_d = START;
      START: begin
        m_enable_o = 1'b1;
        if (busy_s) begin
          m_enable_o = 1'b0;
          state_d    = RUN;
        end else if (tmo_max) begin
          m_enable_o = 1'b0;
          state_d    = DONE;
        end
      end
      RUN: if (!busy_s || tmo_max) state_d = DONE;
      DONE: begin
        done_o  = gnt_q;
        err_o   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // grant, descriptor capture, timeout, error latch and pointer update
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      gnt_q    <= '0;
      gidx_q   <= '0;
      ptr_q    <= IW'(NREQ - 1);
      tmo_q    <= '0;
      err_q    <= 1'b0;
      rw_q     <= 1'b0;
      devadr_q <= '0;
      regadr_q <= '0;
      datnum_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (pick_valid) begin
            gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            gidx_q   <= pick_idx;
            rw_q     <= rw_i[pick_idx];
            devadr_q <= devadr_i[pick_idx*7 +: 7];
            regadr_q <= regadr_i[pick_idx*8 +: 8];
            datnum_q <= datnum_i[pick_idx*5 +: 5];
          end
        end
        START: begin
          if (busy_s)       tmo_q <= '0;
          else if (tmo_max) err_q <= 1'b1;
          else              tmo_q <= tmo_q + 1'b1;
        end
        RUN: begin
          if (deverr_s || (busy_s && tmo_max)) err_q <= 1'b1;
          if (!tmo_max) tmo_q <= tmo_q + 1'b1;
        end
        DONE: begin
          gnt_q <= '0;
          err_q <= 1'b0;
          tmo_q <= '0;
`ifdef I2C_ARB_PRIO_EN
          if (gidx_q != '0) ptr_q <= gidx_q;
`else
          ptr_q <= gidx_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - directed self-checking bench for i2c_arbiter
module tb_i2c_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [3:0]  req_i, rw_i, gnt_o, done_o;
  logic [27:0] devadr_i;
  logic [31:0] regadr_i;
  logic [19:0] datnum_i;
  logic        err_o, m_enable_o, m_rw_o, m_busy_i, m_deverr_i;
  logic [6:0]  m_devadr_o;
  logic [7:0]  m_regadr_o;
  logic [4:0]  m_datnum_o;

  int total = 0;
  int bad   = 0;
  logic [6:0] dev_tab [4] = '{7'h20, 7'h48, 7'h50, 7'h68};

  i2c_arbiter #(.NREQ(4), .TMO_W(6)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .req_i(req_i), .rw_i(rw_i),
    .devadr_i(devadr_i), .regadr_i(regadr_i), .datnum_i(datnum_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .m_enable_o(m_enable_o),
    .m_rw_o(m_rw_o), .m_devadr_o(m_devadr_o), .m_regadr_o(m_regadr_o),
    .m_datnum_o(m_datnum_o), .m_busy_i(m_busy_i), .m_deverr_i(m_deverr_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_en(output logic [3:0] g);
    int n = 0;
    while (!m_enable_o && n < 20) begin
      tick();
      n++;
    end
    chk("enable_wait", {31'd0, m_enable_o}, 32'd1);
    g = gnt_o;
  endtask

  task automatic finish_txn(input int busy_len, input bit dev_err,
                            output logic [3:0] d, output logic e, output int lat);
    int n = 0;
    lat = -1;
    m_busy_i = 1'b1;
    for (int i = 0; i < busy_len; i++) begin
      m_deverr_i = dev_err && (i == 6);
      tick();
      if (lat < 0 && !m_enable_o) lat = i + 1;
    end
    m_deverr_i = 1'b0;
    m_busy_i   = 1'b0;
    while (done_o == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("done_wait", {31'd0, |done_o}, 32'd1);
    d = done_o;
    e = err_o;
  endtask

  initial begin
    logic [3:0] g, d, exp_g;
    logic       e;
    int         lat, k;

    wb_rst_i   = 1'b1;
    req_i      = 4'b0;
    rw_i       = 4'b1010;
    devadr_i   = {7'h68, 7'h50, 7'h48, 7'h20};
    regadr_i   = {8'h33, 8'h22, 8'h11, 8'h00};
    datnum_i   = {5'd4, 5'd3, 5'd2, 5'd1};
    m_busy_i   = 1'b0;
    m_deverr_i = 1'b0;
    tick(); tick();
    wb_rst_i = 1'b0;
    tick();

    chk("rst_gnt", {28'd0, gnt_o}, 32'd0);
    chk("rst_done", {28'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_en", {31'd0, m_enable_o}, 32'd0);
    chk("rst_devadr", {25'd0, m_devadr_o}, 32'd0);

    // single request on requester 1
    req_i = 4'b0010;
    tick();
    chk("single_gnt", {28'd0, gnt_o}, 32'h2);
    chk("single_en", {31'd0, m_enable_o}, 32'd1);
    chk("single_devadr", {25'd0, m_devadr_o}, 32'h48);
    chk("single_regadr", {24'd0, m_regadr_o}, 32'h11);
    chk("single_datnum", {27'd0, m_datnum_o}, 32'd2);
    chk("single_rw", {31'd0, m_rw_o}, 32'd1);
    finish_txn(20, 1'b0, d, e, lat);
    req_i = 4'b0;
    chk("single_en_drop", {31'd0, (lat >= 2 && lat <= 3)}, 32'd1);
    chk("single_done", {28'd0, d}, 32'h2);
    chk("single_err", {31'd0, e}, 32'd0);
    tick();
    chk("single_gnt_clr", {28'd0, gnt_o}, 32'd0);
    chk("single_done_1cyc", {28'd0, done_o}, 32'd0);

    // fairness after a fresh reset
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    req_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_g = 4'b0001 << (i % 4);
      wait_en(g);
      chk("fair_gnt", {28'd0, g}, {28'd0, exp_g});
      chk("fair_onehot", {31'd0, $onehot(g)}, 32'd1);
      chk("fair_devadr", {25'd0, m_devadr_o}, {25'd0, dev_tab[i % 4]});
      finish_txn(5, 1'b0, d, e, lat);
      chk("fair_done", {28'd0, d}, {28'd0, exp_g});
      chk("fair_err", {31'd0, e}, 32'd0);
    end
    req_i = 4'b0;
    tick(); tick();

    // device error on requester 2, then a clean transaction on requester 0
    req_i = 4'b0100;
    wait_en(g);
    finish_txn(20, 1'b1, d, e, lat);
    req_i = 4'b0;
    chk("deverr_done", {28'd0, d}, 32'h4);
    chk("deverr_err", {31'd0, e}, 32'd1);
    tick();
    req_i = 4'b0001;
    wait_en(g);
    finish_txn(8, 1'b0, d, e, lat);
    req_i = 4'b0;
    chk("after_err_done", {28'd0, d}, 32'h1);
    chk("after_err_err", {31'd0, e}, 32'd0);
    tick(); tick();

    // busy never rises
    req_i = 4'b1000;
    wait_en(g);
    chk("hang_gnt", {28'd0, g}, 32'h8);
    k = 0;
    while (done_o == 4'b0 && k < 100) begin
      tick();
      k++;
    end
    req_i = 4'b0;
    chk("hang_latency", k, 32'd64);
    chk("hang_done", {28'd0, done_o}, 32'h8);
    chk("hang_err", {31'd0, err_o}, 32'd1);
    chk("hang_en_low", {31'd0, m_enable_o}, 32'd0);
    tick(); tick();

    // busy stuck high
    req_i = 4'b0001;
    wait_en(g);
    m_busy_i = 1'b1;
    k = 0;
    while (m_enable_o && k < 10) begin
      tick();
      k++;
    end
    k = 0;
    while (done_o == 4'b0 && k < 100) begin
      tick();
      k++;
    end
    req_i = 4'b0;
    chk("stuck_latency", {31'd0, (k >= 63 && k <= 66)}, 32'd1);
    chk("stuck_done", {28'd0, done_o}, 32'h1);
    chk("stuck_err", {31'd0, err_o}, 32'd1);
    m_busy_i = 1'b0;
    tick(); tick(); tick(); tick();

    // reset in the middle of RUN
    req_i = 4'b1000;
    wait_en(g);
    m_busy_i = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_gnt", {28'd0, gnt_o}, 32'h8);
    chk("mid_en", {31'd0, m_enable_o}, 32'd0);
    wb_rst_i = 1'b1;
    #1;
    chk("mid_rst_gnt", {28'd0, gnt_o}, 32'd0);
    chk("mid_rst_en", {31'd0, m_enable_o}, 32'd0);
    chk("mid_rst_done", {28'd0, done_o}, 32'd0);
    tick();
    wb_rst_i = 1'b0;
    m_busy_i = 1'b0;
    req_i    = 4'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_o != 4'b0) k++;
    end
    chk("mid_no_done", k, 32'd0);
    req_i = 4'b1111;
    tick();
    chk("mid_next_gnt", {28'd0, gnt_o}, 32'h1);
    finish_txn(5, 1'b0, d, e, lat);
    req_i = 4'b0;
    chk("mid_next_done", {28'd0, d}, 32'h1);
    tick(); tick();

`ifdef I2C_ARB_PRIO_EN
    // requester 0 takes precedence; others stay round-robin
    req_i = 4'b0010;
    wait_en(g);
    chk("prio_g1", {28'd0, g}, 32'h2);
    req_i = 4'b1101;
    finish_txn(5, 1'b0, d, e, lat);
    wait_en(g);
    chk("prio_g0a", {28'd0, g}, 32'h1);
    req_i = 4'b1100;
    finish_txn(5, 1'b0, d, e, lat);
    wait_en(g);
    chk("prio_g2", {28'd0, g}, 32'h4);
    req_i = 4'b1101;
    finish_txn(5, 1'b0, d, e, lat);
    wait_en(g);
    chk("prio_g0b", {28'd0, g}, 32'h1);
    req_i = 4'b1100;
    finish_txn(5, 1'b0, d, e, lat);
    wait_en(g);
    chk("prio_g3", {28'd0, g}, 32'h8);
    req_i = 4'b0;
    finish_txn(5, 1'b0, d, e, lat);
    tick(); tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
